pc_unit: RTL

- Parametrised program-counter unit for the single-cycle RV32I core; successor to the plain PC register.
- Owns next-PC selection (sequential, branch, jump, trap, mret), stall hold, misaligned-target detection, exception PC save, and a boot/flush state machine.
- Feeds instruction memory address and PC+INC to the datapath (JAL/JALR link value).

---
 rtl/pc_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, stall hold, misaligned redirect trap, EPC save, BOOT/RUN/FLUSH FSM.
// Optional PC_REDIRECT_CNT_EN adds a saturating redirect_cnt output.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_trap,
  output logic [1:0]      state
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  state_t          st, st_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt, redir_tgt;
  logic            mis_nxt, redir_req, redirected;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign state       = st;
  assign pc_valid    = (st == RUN);
  assign pc_plus_inc = pc_out + INC_V;

  // Jump outranks branch; stall suppresses both before alignment is examined.
  assign redir_tgt = jump ? jump_target : branch_target;
  assign redir_req = !stall && (jump || branch_taken);

  always_comb begin
    st_nxt     = st;
    pc_nxt     = pc_out;
    epc_nxt    = epc;
    mis_nxt    = 1'b0;
    redirected = 1'b0;
    case (st)
      BOOT: begin
        pc_nxt = RESET_VECTOR;
        st_nxt = RUN;
      end
      RUN: begin
        if (trap_req) begin
          epc_nxt    = pc_out;
          pc_nxt     = TRAP_VECTOR;
          st_nxt     = FLUSH;
          redirected = 1'b1;
        end else if (mret) begin
          pc_nxt     = epc;
          redirected = 1'b1;
        end else if (stall) begin
          pc_nxt = pc_out;
        end else if (redir_req) begin
          redirected = 1'b1;
          if (redir_tgt[1:0] != 2'b00) begin
            epc_nxt = pc_out;
            pc_nxt  = TRAP_VECTOR;
            mis_nxt = 1'b1;
            st_nxt  = FLUSH;
          end else begin
            pc_nxt = redir_tgt;
          end
        end else begin
          pc_nxt = pc_out + INC_V;
        end
      end
      FLUSH: begin
        st_nxt = RUN;
      end
      default: begin
        pc_nxt = RESET_VECTOR;
        st_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= BOOT;
      pc_out        <= RESET_VECTOR;
      epc           <= '0;
      misalign_trap <= 1'b0;
    end else begin
      st            <= st_nxt;
      pc_out        <= pc_nxt;
      epc           <= epc_nxt;
      misalign_trap <= mis_nxt;
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= 32'd0;
    end else if (redirected) begin
      redirect_cnt <= sat_inc(redirect_cnt);
    end
  end
`endif

endmodule
